instruction_decode: RTL and testbench

Second pipeline stage of the RISC-V small core, directly downstream of the instruction fetch stage. It consumes the registered instruction and PC from fetch, drives the register-file read ports, and generates the sign-extended immediate and control fields. It registers everything into the ID/EX pipeline register. It also detects load-use hazards, requesting a fetch stall, and inserts bubbles on stall or flush.

---
 rtl/instruction_decode.sv | 215 +++++++++++++++++++++
 tb/tb_instruction_decode.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// RV32I decode stage: register-file addressing, immediate/control generation,
// load-use hazard detection and the ID/EX pipeline register.
module instruction_decode #(
  parameter int ARCH_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [INST_WIDTH-1:0] inst_id,
  input  logic [ARCH_WIDTH-1:0] pc_id,
  input  logic                  flush,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  input  logic [ARCH_WIDTH-1:0] rs1_data,
  input  logic [ARCH_WIDTH-1:0] rs2_data,
  output logic                  stall,
  output logic [ARCH_WIDTH-1:0] pc_ex,
  output logic [ARCH_WIDTH-1:0] rs1_data_ex,
  output logic [ARCH_WIDTH-1:0] rs2_data_ex,
  output logic [ARCH_WIDTH-1:0] imm_ex,
  output logic [4:0]            rd_ex,
  output logic [4:0]            rs1_ex,
  output logic [4:0]            rs2_ex,
  output logic [2:0]            funct3_ex,
  output logic [3:0]            alu_op_ex,
  output logic [1:0]            alu_src_a_ex,
  output logic                  alu_src_b_ex,
  output logic [1:0]            wb_sel_ex,
  output logic                  reg_write_ex,
  output logic                  mem_read_ex,
  output logic                  mem_write_ex,
  output logic                  branch_ex,
  output logic                  jump_ex,
  output logic                  illegal_ex
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;

  assign opcode   = inst_id[6:0];
  assign rd_field = inst_id[11:7];
  assign funct3   = inst_id[14:12];
  assign rs1_addr = inst_id[19:15];
  assign rs2_addr = inst_id[24:20];
  assign funct7   = inst_id[31:25];

  logic        legal, is_zero, use_rs1, use_rs2, has_rd;
  logic [31:0] imm32;
  logic [3:0]  alu_op_d;
  logic [1:0]  src_a_d, wb_sel_d;
  logic        src_b_d, reg_write_d, mem_read_d, mem_write_d, branch_d, jump_d;

  always_comb begin
    legal       = 1'b1;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    has_rd      = 1'b0;
    imm32       = '0;
    alu_op_d    = 4'b0000;
    src_a_d     = 2'd0;
    src_b_d     = 1'b0;
    wb_sel_d    = 2'd0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm32 = {inst_id[31:12], 12'b0};
        has_rd = 1'b1; reg_write_d = 1'b1; src_a_d = 2'd2; src_b_d = 1'b1;
      end
      OPC_AUIPC: begin
        imm32 = {inst_id[31:12], 12'b0};
        has_rd = 1'b1; reg_write_d = 1'b1; src_a_d = 2'd1; src_b_d = 1'b1;
      end
      OPC_JAL: begin
        imm32 = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};
        has_rd = 1'b1; reg_write_d = 1'b1; jump_d = 1'b1; wb_sel_d = 2'd2;
        src_a_d = 2'd1; src_b_d = 1'b1;
      end
      OPC_JALR: begin
        imm32 = {{20{inst_id[31]}}, inst_id[31:20]};
        use_rs1 = 1'b1; has_rd = 1'b1; reg_write_d = 1'b1; jump_d = 1'b1;
        wb_sel_d = 2'd2; src_b_d = 1'b1;
      end
      OPC_BRANCH: begin
        imm32 = {{19{inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
        use_rs1 = 1'b1; use_rs2 = 1'b1; branch_d = 1'b1; alu_op_d = 4'b1000;
      end
      OPC_LOAD: begin
        imm32 = {{20{inst_id[31]}}, inst_id[31:20]};
        use_rs1 = 1'b1; has_rd = 1'b1; reg_write_d = 1'b1; mem_read_d = 1'b1;
        wb_sel_d = 2'd1; src_b_d = 1'b1;
      end
      OPC_STORE: begin
        imm32 = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
        use_rs1 = 1'b1; use_rs2 = 1'b1; mem_write_d = 1'b1; src_b_d = 1'b1;
      end
      OPC_OPIMM: begin
        imm32 = {{20{inst_id[31]}}, inst_id[31:20]};
        use_rs1 = 1'b1; has_rd = 1'b1; reg_write_d = 1'b1; src_b_d = 1'b1;
        alu_op_d = {(funct3 == 3'b101) ? inst_id[30] : 1'b0, funct3};
        // Only the shift encodings constrain the upper immediate bits.
        if (funct3 == 3'b001)
          legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1; reg_write_d = 1'b1;
        alu_op_d = {inst_id[30], funct3};
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_FENCE, OPC_SYSTEM: begin
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (rd_field == 5'd0)
      reg_write_d = 1'b0;
  end

  assign is_zero = (inst_id[31:0] == 32'h0);

  logic hazard;
  assign hazard = mem_read_ex && (rd_ex != 5'd0) && legal && !is_zero &&
                  ((use_rs1 && (rd_ex == rs1_addr)) || (use_rs2 && (rd_ex == rs2_addr)));
  assign stall  = hazard && !flush;

  logic load_bubble, load_illegal;
  assign load_bubble  = flush || hazard || is_zero;
  assign load_illegal = !load_bubble && !legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_ex        <= '0;
      rs1_data_ex  <= '0;
      rs2_data_ex  <= '0;
      imm_ex       <= '0;
      rd_ex        <= '0;
      rs1_ex       <= '0;
      rs2_ex       <= '0;
      funct3_ex    <= '0;
      alu_op_ex    <= '0;
      alu_src_a_ex <= '0;
      alu_src_b_ex <= 1'b0;
      wb_sel_ex    <= '0;
      reg_write_ex <= 1'b0;
      mem_read_ex  <= 1'b0;
      mem_write_ex <= 1'b0;
      branch_ex    <= 1'b0;
      jump_ex      <= 1'b0;
      illegal_ex   <= 1'b0;
    end else if (clk_en) begin
      if (load_bubble || load_illegal) begin
        // Illegal instructions keep their PC so the trap logic can report it.
        pc_ex        <= load_illegal ? pc_id : '0;
        rs1_data_ex  <= '0;
        rs2_data_ex  <= '0;
        imm_ex       <= '0;
        rd_ex        <= '0;
        rs1_ex       <= '0;
        rs2_ex       <= '0;
        funct3_ex    <= '0;
        alu_op_ex    <= '0;
        alu_src_a_ex <= '0;
        alu_src_b_ex <= 1'b0;
        wb_sel_ex    <= '0;
        reg_write_ex <= 1'b0;
        mem_read_ex  <= 1'b0;
        mem_write_ex <= 1'b0;
        branch_ex    <= 1'b0;
        jump_ex      <= 1'b0;
        illegal_ex   <= load_illegal;
      end else begin
        pc_ex        <= pc_id;
        rs1_data_ex  <= rs1_data;
        rs2_data_ex  <= rs2_data;
        imm_ex       <= ARCH_WIDTH'($signed(imm32));
        rd_ex        <= has_rd ? rd_field : 5'd0;
        rs1_ex       <= use_rs1 ? rs1_addr : 5'd0;
        rs2_ex       <= use_rs2 ? rs2_addr : 5'd0;
        funct3_ex    <= funct3;
        alu_op_ex    <= alu_op_d;
        alu_src_a_ex <= src_a_d;
        alu_src_b_ex <= src_b_d;
        wb_sel_ex    <= wb_sel_d;
        reg_write_ex <= reg_write_d;
        mem_read_ex  <= mem_read_d;
        mem_write_ex <= mem_write_d;
        branch_ex    <= branch_d;
        jump_ex      <= jump_d;
        illegal_ex   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed RV32I vectors, hazard,
// flush, clock-enable hold and asynchronous reset.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_en = 1'b1;
  logic [31:0] inst_id = '0;
  logic [31:0] pc_id = '0;
  logic        flush = 1'b0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic        stall;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rd_ex, rs1_ex, rs2_ex;
  logic [2:0]  funct3_ex;
  logic [3:0]  alu_op_ex;
  logic [1:0]  alu_src_a_ex, wb_sel_ex;
  logic        alu_src_b_ex, reg_write_ex, mem_read_ex, mem_write_ex;
  logic        branch_ex, jump_ex, illegal_ex;

  always #5 clk = ~clk;

  instruction_decode #(.ARCH_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .inst_id(inst_id), .pc_id(pc_id),
    .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .pc_ex(pc_ex),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .rd_ex(rd_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .funct3_ex(funct3_ex),
    .alu_op_ex(alu_op_ex), .alu_src_a_ex(alu_src_a_ex), .alu_src_b_ex(alu_src_b_ex),
    .wb_sel_ex(wb_sel_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .mem_write_ex(mem_write_ex), .branch_ex(branch_ex), .jump_ex(jump_ex),
    .illegal_ex(illegal_ex)
  );

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [1:0]  sa;
    logic        sb;
    logic [1:0]  wb;
    logic        rw, mr, mw, br, jp, ill;
  } ex_t;

  ex_t   sb_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;

  function automatic ex_t mk(logic [31:0] pc, logic [31:0] rs1d, logic [31:0] rs2d,
                             logic [31:0] imm, logic [4:0] rd, logic [4:0] rs1,
                             logic [4:0] rs2, logic [2:0] f3, logic [3:0] alu,
                             logic [1:0] sa, logic sb, logic [1:0] wb, logic rw,
                             logic mr, logic mw, logic br, logic jp, logic ill);
    ex_t e;
    e.pc = pc; e.rs1d = rs1d; e.rs2d = rs2d; e.imm = imm;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.alu = alu;
    e.sa = sa; e.sb = sb; e.wb = wb;
    e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.jp = jp; e.ill = ill;
    return e;
  endfunction

  function automatic ex_t actual();
    return mk(pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rd_ex, rs1_ex, rs2_ex,
              funct3_ex, alu_op_ex, alu_src_a_ex, alu_src_b_ex, wb_sel_ex,
              reg_write_ex, mem_read_ex, mem_write_ex, branch_ex, jump_ex, illegal_ex);
  endfunction

  function automatic ex_t illegal_at(logic [31:0] pc);
    ex_t e = '0;
    e.pc = pc;
    e.ill = 1'b1;
    return e;
  endfunction

  task automatic check_ex(string nm, ex_t want);
    ex_t got = actual();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end else
      $display("ok   %s: ex=%h", nm, got);
  endtask

  task automatic check_stall(string nm, logic want);
    total++;
    if (stall !== want) begin
      bad++;
      $display("FAIL %s stall: got %b want %b", nm, stall, want);
    end
  endtask

  // Called right after a falling edge; returns at the next falling edge.
  task automatic step(string nm, logic [31:0] inst, logic [31:0] pc,
                      logic [31:0] d1, logic [31:0] d2, logic fl,
                      logic exp_stall, ex_t want);
    inst_id = inst; pc_id = pc; rs1_data = d1; rs2_data = d2; flush = fl;
    #1;
    check_stall(nm, exp_stall);
    sb_q.push_back(want);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // Monitor: every enabled, out-of-reset edge must match the next queued entry.
  always @(posedge clk) begin
    logic en_s, rst_s;
    en_s  = clk_en;
    rst_s = rst_n;
    #1;
    if (en_s && rst_s) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_update: got %h want no update", actual());
      end else begin
        ex_t   want;
        string nm;
        want = sb_q.pop_front();
        nm   = name_q.pop_front();
        check_ex(nm, want);
      end
    end
  end

  localparam logic [31:0] ADDI   = 32'h00500093;
  localparam logic [31:0] LW     = 32'h0000A103;
  localparam logic [31:0] ADD    = 32'h001101B3;
  localparam logic [31:0] BEQ    = 32'hFE000EE3;
  localparam logic [31:0] SUB    = 32'h407302B3;
  localparam logic [31:0] SRAI   = 32'h4034D413;
  localparam logic [31:0] ADDI_H = 32'h40008093;
  localparam logic [31:0] LUI    = 32'h12345537;
  localparam logic [31:0] JAL    = 32'h008000EF;
  localparam logic [31:0] JALR   = 32'h00008067;
  localparam logic [31:0] SW     = 32'h0020A423;
  localparam logic [31:0] AUIPC  = 32'h00001217;
  localparam logic [31:0] BADOP  = 32'hFFFFFFFF;
  localparam logic [31:0] BADSLL = 32'h40001013;

  initial begin
    ex_t add_late;
    add_late = mk(32'h14, 32'h33, 32'h44, 0, 3, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_ex("reset", '0);
    check_stall("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step("addi", ADDI, 32'h0, 32'h0, 32'h11, 0, 0,
         mk(32'h0, 32'h0, 32'h11, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    step("lw", LW, 32'h4, 32'h1000, 32'h22, 0, 0,
         mk(32'h4, 32'h1000, 32'h22, 0, 2, 1, 0, 2, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    step("add_stalled", ADD, 32'h8, 32'h99, 32'h98, 0, 1, '0);
    step("add", ADD, 32'h8, 32'h33, 32'h44, 0, 0,
         mk(32'h8, 32'h33, 32'h44, 0, 3, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step("beq", BEQ, 32'h100, 32'h5, 32'h6, 0, 0,
         mk(32'h100, 32'h5, 32'h6, 32'hFFFFFFFC, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step("sub", SUB, 32'h104, 32'h7, 32'h8, 0, 0,
         mk(32'h104, 32'h7, 32'h8, 0, 5, 6, 7, 0, 4'b1000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step("srai", SRAI, 32'h108, 32'h9, 32'hA, 0, 0,
         mk(32'h108, 32'h9, 32'hA, 32'h403, 8, 9, 0, 5, 4'b1101, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    step("addi_bit30", ADDI_H, 32'h10C, 32'h1, 32'h2, 0, 0,
         mk(32'h10C, 32'h1, 32'h2, 32'h400, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    step("lui", LUI, 32'h110, 32'h3, 32'h4, 0, 0,
         mk(32'h110, 32'h3, 32'h4, 32'h12345000, 10, 0, 0, 5, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0));
    step("jal", JAL, 32'h200, 32'h0, 32'h0, 0, 0,
         mk(32'h200, 32'h0, 32'h0, 32'h8, 1, 0, 0, 0, 0, 1, 1, 2, 1, 0, 0, 0, 1, 0));
    step("jalr_x0", JALR, 32'h204, 32'h500, 32'h0, 0, 0,
         mk(32'h204, 32'h500, 32'h0, 0, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0));
    step("sw", SW, 32'h208, 32'h600, 32'h77, 0, 0,
         mk(32'h208, 32'h600, 32'h77, 32'h8, 0, 1, 2, 2, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    step("auipc", AUIPC, 32'h20C, 32'h0, 32'h0, 0, 0,
         mk(32'h20C, 32'h0, 32'h0, 32'h1000, 4, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    step("illegal_op", BADOP, 32'h300, 32'h1, 32'h2, 0, 0, illegal_at(32'h300));
    step("illegal_sll", BADSLL, 32'h304, 32'h1, 32'h2, 0, 0, illegal_at(32'h304));
    step("zero_inst", 32'h0, 32'h308, 32'h1, 32'h2, 0, 0, '0);
    step("lw2", LW, 32'h10, 32'h1000, 32'h22, 0, 0,
         mk(32'h10, 32'h1000, 32'h22, 0, 2, 1, 0, 2, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    step("add_flush", ADD, 32'h14, 32'h33, 32'h44, 1, 0, '0);
    step("add_after_flush", ADD, 32'h14, 32'h33, 32'h44, 0, 0, add_late);

    // Clock-enable hold while the ID inputs keep changing.
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inst_id  = (k == 0) ? LW : (k == 1) ? SUB : BEQ;
      pc_id    = 32'h400 + 32'(k * 4);
      rs1_data = 32'hDEAD0000 + 32'(k);
      #1;
      check_ex($sformatf("hold_%0d", k), add_late);
      @(negedge clk);
    end

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_ex("async_reset", '0);
    check_stall("async_reset", 1'b0);
    repeat (2) @(negedge clk);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
